// File: rtl/seg_mon_pkg.sv
// Shared types and helpers for the wheel-speed averaging monitor.
package seg_mon_pkg;

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} mon_state_t;

  typedef enum logic [1:0] {TRD_NONE, TRD_UP, TRD_DOWN, TRD_SAME} trend_t;

  localparam int unsigned ABS_W = 32;

  // Callers sign-extend narrower operands to ABS_W. The extra result bit makes the difference exact.
  function automatic logic [ABS_W:0] abs_diff(input logic signed [ABS_W-1:0] a,
                                               input logic signed [ABS_W-1:0] b);
    logic signed [ABS_W:0] d;
    d = {a[ABS_W-1], a} - {b[ABS_W-1], b};
    return d[ABS_W] ? -d : d;
  endfunction

endpackage

// File: rtl/spd_accum.sv
// Per-wheel window accumulator. It computes the window average and the trend against the previous window.
module spd_accum
  import seg_mon_pkg::*;
#(
  parameter int SPD_W     = 12,
  parameter int LOG2_SAMP = 10,
  parameter int TREND_TOL = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr_i,
  input  logic                    acc_en_i,
  input  logic                    fin_i,
  input  logic signed [SPD_W-1:0] spd_i,
  output logic signed [SPD_W-1:0] avg_o,
  output trend_t                  trend_o
);

  localparam int ACC_W = SPD_W + LOG2_SAMP;

  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [SPD_W-1:0] avg_q, avg_d, prev_q;
  logic                    prev_vld_q;
  logic signed [SPD_W:0]   diff;
  trend_t                  trend_q, trend_d;

  // The average is taken from the sum that includes the final sample, so it is ready on the same edge.
  always_comb begin
    acc_d   = acc_q + ACC_W'(spd_i);
    avg_d   = SPD_W'(acc_d >>> LOG2_SAMP);
    diff    = (SPD_W+1)'(avg_d) - (SPD_W+1)'(prev_q);
    trend_d = TRD_SAME;
    if (!prev_vld_q)                         trend_d = TRD_NONE;
    else if (diff > (SPD_W+1)'(TREND_TOL))   trend_d = TRD_UP;
    else if (diff < (SPD_W+1)'(-TREND_TOL))  trend_d = TRD_DOWN;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q      <= '0;
      avg_q      <= '0;
      prev_q     <= '0;
      prev_vld_q <= 1'b0;
      trend_q    <= TRD_NONE;
    end else begin
      if (clr_i)         acc_q <= '0;
      else if (acc_en_i) acc_q <= acc_d;
      if (fin_i) begin
        avg_q      <= avg_d;
        trend_q    <= trend_d;
        prev_q     <= avg_d;
        prev_vld_q <= 1'b1;
      end
    end
  end

  assign avg_o   = avg_q;
  assign trend_o = trend_q;

endmodule

// File: rtl/speed_avg_mon.sv
// Wheel-speed monitor. It averages left and right speeds over 2^LOG2_SAMP samples and flags divergence between them.
module speed_avg_mon
  import seg_mon_pkg::*;
#(
  parameter int SPD_W        = 12,
  parameter int LOG2_SAMP    = 10,
  parameter int MISMATCH_TOL = 10,
  parameter int TREND_TOL    = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    samp_en,
  input  logic signed [SPD_W-1:0] lft_spd,
  input  logic signed [SPD_W-1:0] rght_spd,
  output logic                    busy,
  output logic                    avg_vld,
  output logic signed [SPD_W-1:0] lft_avg,
  output logic signed [SPD_W-1:0] rght_avg,
  output logic [1:0]              lft_trend,
  output logic [1:0]              rght_trend,
  output logic                    mismatch,
  output logic [LOG2_SAMP:0]      mismatch_cnt
);

  mon_state_t           state_q, state_d;
  logic [LOG2_SAMP-1:0] cnt_q;
  logic                 mis_q;
  logic [LOG2_SAMP:0]   mis_cnt_q;
  logic                 clr, acc_en, fin, over_tol;
  logic [ABS_W:0]       spd_diff;
  trend_t               lft_trd, rght_trd;

  // A start in ACCUM takes priority over a coincident sample, so that sample is discarded.
  assign clr      = start && (state_q != DONE);
  assign acc_en   = (state_q == ACCUM) && samp_en && !start;
  assign fin      = acc_en && (cnt_q == '1);
  assign spd_diff = abs_diff(ABS_W'(lft_spd), ABS_W'(rght_spd));
  assign over_tol = spd_diff > (ABS_W+1)'(MISMATCH_TOL);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = ACCUM;
      ACCUM:   if (fin)   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      mis_q     <= 1'b0;
      mis_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (clr) begin
        cnt_q     <= '0;
        mis_q     <= 1'b0;
        mis_cnt_q <= '0;
      end else if (acc_en) begin
        cnt_q <= cnt_q + 1'b1;
        if (over_tol) begin
          mis_q <= 1'b1;
          if (mis_cnt_q != '1) mis_cnt_q <= mis_cnt_q + 1'b1;
        end
      end
    end
  end

  spd_accum #(.SPD_W(SPD_W), .LOG2_SAMP(LOG2_SAMP), .TREND_TOL(TREND_TOL)) u_lft (
    .clk(clk), .rst(rst), .clr_i(clr), .acc_en_i(acc_en), .fin_i(fin),
    .spd_i(lft_spd), .avg_o(lft_avg), .trend_o(lft_trd)
  );

  spd_accum #(.SPD_W(SPD_W), .LOG2_SAMP(LOG2_SAMP), .TREND_TOL(TREND_TOL)) u_rght (
    .clk(clk), .rst(rst), .clr_i(clr), .acc_en_i(acc_en), .fin_i(fin),
    .spd_i(rght_spd), .avg_o(rght_avg), .trend_o(rght_trd)
  );

  assign busy         = (state_q == ACCUM);
  assign avg_vld      = (state_q == DONE);
  assign lft_trend    = lft_trd;
  assign rght_trend   = rght_trd;
  assign mismatch     = mis_q;
  assign mismatch_cnt = mis_cnt_q;

endmodule

// File: tb/tb_speed_avg_mon.sv
// Self-checking bench for speed_avg_mon with a 16-sample window. It checks the DUT against an arithmetic window model.
module tb_speed_avg_mon;

  localparam int SPD_W = 12;
  localparam int L     = 4;
  localparam int NS    = 16;
  localparam int MT    = 10;
  localparam int TT    = 4;

  logic                    clk = 1'b0;
  logic                    rst, start, samp_en;
  logic signed [SPD_W-1:0] lft_spd, rght_spd;
  logic                    busy, avg_vld, mismatch;
  logic signed [SPD_W-1:0] lft_avg, rght_avg;
  logic [1:0]              lft_trend, rght_trend;
  logic [L:0]              mismatch_cnt;

  speed_avg_mon #(.SPD_W(SPD_W), .LOG2_SAMP(L), .MISMATCH_TOL(MT), .TREND_TOL(TT)) dut (
    .clk(clk), .rst(rst), .start(start), .samp_en(samp_en),
    .lft_spd(lft_spd), .rght_spd(rght_spd), .busy(busy), .avg_vld(avg_vld),
    .lft_avg(lft_avg), .rght_avg(rght_avg), .lft_trend(lft_trend), .rght_trend(rght_trend),
    .mismatch(mismatch), .mismatch_cnt(mismatch_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state and window contents.
  int wl[NS];
  int wr[NS];
  int pv, prev_l, prev_r;
  int e_l, e_r, e_mc;
  logic [1:0] e_lt, e_rt;
  logic e_mis;

  // Values observed from the last window.
  int o_l, o_r, o_mc, o_early, o_busy_low;
  logic [1:0] o_lt, o_rt;
  logic o_mis, o_got, o_busy_after, o_vld_after;

  function automatic int floor_avg(input int s);
    int q;
    q = s / NS;
    if ((s % NS) != 0 && s < 0) q = q - 1;
    return q;
  endfunction

  function automatic logic [1:0] trend_of(input int a, input int p, input int v);
    if (v == 0) return 2'd0;
    if (a - p > TT) return 2'd1;
    if (a - p < -TT) return 2'd2;
    return 2'd3;
  endfunction

  function automatic int rnd_spd();
    return int'($urandom_range(0, 4095)) - 2048;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_window();
    int sl, sr, d;
    sl = 0; sr = 0; e_mc = 0;
    for (int i = 0; i < NS; i++) begin
      sl += wl[i];
      sr += wr[i];
      d = wl[i] - wr[i];
      if (d < 0) d = -d;
      if (d > MT) e_mc++;
    end
    e_l   = floor_avg(sl);
    e_r   = floor_avg(sr);
    e_lt  = trend_of(e_l, prev_l, pv);
    e_rt  = trend_of(e_r, prev_r, pv);
    e_mis = (e_mc > 0);
    prev_l = e_l;
    prev_r = e_r;
    pv     = 1;
  endtask

  // Drives one window. A nonzero n_abort first feeds that many junk samples and then restarts.
  task automatic run_window(input int n_abort, input bit gaps);
    o_early = 0; o_busy_low = 0;
    start = 1'b1; samp_en = 1'b1; lft_spd = 12'sd2047; rght_spd = -12'sd2048;
    step();
    start = 1'b0; samp_en = 1'b0;
    if (n_abort > 0) begin
      for (int k = 0; k < n_abort; k++) begin
        if (busy !== 1'b1) o_busy_low++;
        if (avg_vld !== 1'b0) o_early++;
        samp_en = 1'b1; lft_spd = 12'(rnd_spd()); rght_spd = 12'(rnd_spd());
        step();
      end
      if (busy !== 1'b1) o_busy_low++;
      start = 1'b1; samp_en = 1'b1; lft_spd = 12'sd2047; rght_spd = -12'sd2048;
      step();
      start = 1'b0; samp_en = 1'b0;
    end
    for (int i = 0; i < NS; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        if (busy !== 1'b1) o_busy_low++;
        if (avg_vld !== 1'b0) o_early++;
        samp_en = 1'b0; lft_spd = 12'(rnd_spd()); rght_spd = 12'(rnd_spd());
        step();
      end
      if (busy !== 1'b1) o_busy_low++;
      if (avg_vld !== 1'b0) o_early++;
      samp_en = 1'b1; lft_spd = 12'(wl[i]); rght_spd = 12'(wr[i]);
      step();
      samp_en = 1'b0;
    end
    o_got = avg_vld; o_busy_after = busy;
    o_l = int'(lft_avg); o_r = int'(rght_avg);
    o_lt = lft_trend; o_rt = rght_trend;
    o_mis = mismatch; o_mc = int'(mismatch_cnt);
    step();
    o_vld_after = avg_vld;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; samp_en = 1'b0; lft_spd = '0; rght_spd = '0;
    pv = 0; prev_l = 0; prev_r = 0;
    repeat (3) step();
    rst = 1'b0;
    for (int c = 0; c < 100; c++) begin
      samp_en = c[0]; lft_spd = 12'(rnd_spd()); rght_spd = 12'(rnd_spd());
      step();
      total++;
      if ({busy, avg_vld, lft_avg, rght_avg, lft_trend, rght_trend, mismatch, mismatch_cnt} !== '0) begin
        bad++;
        $display("FAIL reset_idle cycle %0d: busy=%b vld=%b la=%0d ra=%0d lt=%0d rt=%0d mis=%b mc=%0d required all zero",
                 c, busy, avg_vld, lft_avg, rght_avg, lft_trend, rght_trend, mismatch, mismatch_cnt);
      end
    end
    samp_en = 1'b0;
  endtask

  task automatic test_trend();
    int lvl[3] = '{100, 200, 198};
    for (int w = 0; w < 3; w++) begin
      for (int i = 0; i < NS; i++) begin wl[i] = lvl[w]; wr[i] = lvl[w]; end
      run_window(0, 1'b0);
      model_window();
      total++;
      if (o_got !== 1'b1 || o_early != 0 || o_vld_after !== 1'b0 || o_busy_after !== 1'b0) begin
        bad++;
        $display("FAIL trend_latency w%0d: vld_at=%b early=%0d vld_after=%b busy_after=%b required 1/0/0/0",
                 w, o_got, o_early, o_vld_after, o_busy_after);
      end
      total++;
      if (o_l != e_l || o_r != e_r || o_lt !== e_lt || o_rt !== e_rt || o_mis !== 1'b0) begin
        bad++;
        $display("FAIL trend_values w%0d: l=%0d r=%0d lt=%0d rt=%0d mis=%b required %0d %0d %0d %0d 0",
                 w, o_l, o_r, o_lt, o_rt, o_mis, e_l, e_r, e_lt, e_rt);
      end
    end
  endtask

  task automatic test_floor();
    for (int i = 0; i < NS; i++) begin wl[i] = (i % 2 == 0) ? -3 : -2; wr[i] = -100; end
    run_window(0, 1'b1);
    model_window();
    total++;
    if (o_got !== 1'b1 || o_l != e_l || o_r != e_r || o_l != -3) begin
      bad++;
      $display("FAIL floor_avg: vld=%b l=%0d r=%0d required 1 %0d %0d", o_got, o_l, o_r, e_l, e_r);
    end
    total++;
    if (o_lt !== e_lt || o_rt !== e_rt) begin
      bad++;
      $display("FAIL floor_trend: lt=%0d rt=%0d required %0d %0d", o_lt, o_rt, e_lt, e_rt);
    end
  endtask

  task automatic test_mismatch();
    int picked;
    for (int i = 0; i < NS; i++) begin wl[i] = 50; wr[i] = 60; end
    picked = 0;
    while (picked < 5) begin
      int p;
      p = int'($urandom_range(0, NS - 1));
      if (wr[p] == 60) begin wr[p] = 61; picked++; end
    end
    run_window(0, 1'b1);
    model_window();
    total++;
    if (o_mis !== 1'b1 || o_mc != 5 || o_mc != e_mc) begin
      bad++;
      $display("FAIL mismatch_count: mis=%b cnt=%0d required 1 %0d", o_mis, o_mc, e_mc);
    end
    repeat (3) step();
    total++;
    if (mismatch !== 1'b1 || int'(mismatch_cnt) != e_mc || int'(lft_avg) != e_l) begin
      bad++;
      $display("FAIL mismatch_hold: mis=%b cnt=%0d la=%0d required 1 %0d %0d", mismatch, mismatch_cnt, lft_avg, e_mc, e_l);
    end
  endtask

  task automatic test_back_to_back_restart();
    for (int i = 0; i < NS; i++) begin wl[i] = 300 + i; wr[i] = 300 - i; end
    run_window(7, 1'b1);
    model_window();
    total++;
    if (o_busy_low != 0 || o_early != 0 || o_got !== 1'b1) begin
      bad++;
      $display("FAIL restart_ctl: busy_low=%0d early_vld=%0d vld=%b required 0 0 1", o_busy_low, o_early, o_got);
    end
    total++;
    if (o_l != e_l || o_r != e_r || o_lt !== e_lt || o_rt !== e_rt || o_mc != e_mc) begin
      bad++;
      $display("FAIL restart_values: l=%0d r=%0d lt=%0d rt=%0d mc=%0d required %0d %0d %0d %0d %0d",
               o_l, o_r, o_lt, o_rt, o_mc, e_l, e_r, e_lt, e_rt, e_mc);
    end
  endtask

  task automatic test_random();
    for (int w = 0; w < 6; w++) begin
      int base;
      base = rnd_spd() / 2;
      for (int i = 0; i < NS; i++) begin
        wl[i] = base + int'($urandom_range(0, 40)) - 20;
        wr[i] = wl[i] + int'($urandom_range(0, 26)) - 13;
        if (w == 5) begin wl[i] = rnd_spd(); wr[i] = rnd_spd(); end
      end
      run_window(0, 1'b1);
      model_window();
      total++;
      if (o_got !== 1'b1 || o_early != 0 || o_busy_low != 0 || o_l != e_l || o_r != e_r ||
          o_lt !== e_lt || o_rt !== e_rt || o_mis !== e_mis || o_mc != e_mc) begin
        bad++;
        $display("FAIL random_w%0d: vld=%b early=%0d l=%0d r=%0d lt=%0d rt=%0d mis=%b mc=%0d required 1 0 %0d %0d %0d %0d %b %0d",
                 w, o_got, o_early, o_l, o_r, o_lt, o_rt, o_mis, o_mc, e_l, e_r, e_lt, e_rt, e_mis, e_mc);
      end
    end
  endtask

  task automatic test_rst_mid();
    start = 1'b1; step(); start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      samp_en = 1'b1; lft_spd = 12'(rnd_spd()); rght_spd = 12'(rnd_spd()); step();
    end
    samp_en = 1'b0;
    rst = 1'b1; step(); rst = 1'b0;
    pv = 0; prev_l = 0; prev_r = 0;
    total++;
    if ({busy, avg_vld, lft_avg, rght_avg, lft_trend, rght_trend, mismatch, mismatch_cnt} !== '0) begin
      bad++;
      $display("FAIL rst_mid: busy=%b vld=%b la=%0d ra=%0d lt=%0d rt=%0d mis=%b mc=%0d required all zero",
               busy, avg_vld, lft_avg, rght_avg, lft_trend, rght_trend, mismatch, mismatch_cnt);
    end
    for (int i = 0; i < NS; i++) begin wl[i] = 500; wr[i] = 480; end
    run_window(0, 1'b0);
    model_window();
    total++;
    if (o_lt !== 2'd0 || o_rt !== 2'd0 || o_l != e_l || o_r != e_r || o_mc != e_mc) begin
      bad++;
      $display("FAIL rst_mid_next: lt=%0d rt=%0d l=%0d r=%0d mc=%0d required 0 0 %0d %0d %0d",
               o_lt, o_rt, o_l, o_r, o_mc, e_l, e_r, e_mc);
    end
  endtask

  initial begin
    test_reset();
    test_trend();
    test_floor();
    test_mismatch();
    test_back_to_back_restart();
    test_random();
    test_rst_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
